// File: rtl/svm_coeff_loader.sv
// svm_coeff_loader: register-bus master that programs the slidevm coefficient
// memory. Writes LOAD to the mode register, forwards NCOEFF sign-extended
// coefficients to the coefficient port, waits GAPCYC idle cycles, then writes
// RUN. An abort request or a stalled stream writes STOP instead and flags err_o.
module svm_coeff_loader #(
    parameter int          CWIDTH    = 9,
    parameter int          NCOEFF    = 1024,
    parameter int          GAPCYC    = 4,
    parameter int          TIMEOUT   = 4096,
    parameter logic [31:0] MODE_LOAD = 32'd2,
    parameter logic [31:0] MODE_RUN  = 32'd1,
    parameter logic [31:0] MODE_STOP = 32'd0,
    localparam int         CNTW      = $clog2(NCOEFF + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              coeff_dv_i,
    input  logic [CWIDTH-1:0] coeff_data_i,
    output logic              coeff_ready_o,
    output logic              addr_rel_o,
    output logic              wr_o,
    output logic [31:0]       datawr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNTW-1:0]   count_o
);

    localparam int TOW  = $clog2(TIMEOUT);
    localparam int GAPW = $clog2(GAPCYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_LOAD,
        S_STREAM,
        S_GAP,
        S_CMD_RUN,
        S_DONE,
        S_CMD_STOP
    } state_t;

    state_t          state;
    logic [TOW-1:0]  to_cnt;
    logic [GAPW-1:0] gap_cnt;
    logic            accept;
    logic            timeout_hit;
    logic            abort_now;
    logic [31:0]     coeff_sext;

    // Ready is the only combinational output; an abort request blocks the offer.
    always_comb begin
        coeff_ready_o = (state == S_STREAM) && (count_o != CNTW'(NCOEFF)) && !abort_i;
        accept        = coeff_ready_o && coeff_dv_i;
        timeout_hit   = (state == S_STREAM) && !accept && (to_cnt == TOW'(TIMEOUT - 1));
        abort_now     = (state != S_IDLE) && (state != S_CMD_STOP) && (abort_i || timeout_hit);
        coeff_sext    = {{(32 - CWIDTH){coeff_data_i[CWIDTH-1]}}, coeff_data_i};
    end

    // Load sequencer with registered bus outputs; the abort path overrides the case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            addr_rel_o <= 1'b0;
            wr_o       <= 1'b0;
            datawr_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            count_o    <= '0;
        end else begin
            wr_o   <= 1'b0;
            done_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state      <= S_CMD_LOAD;
                        busy_o     <= 1'b1;
                        wr_o       <= 1'b1;
                        addr_rel_o <= 1'b0;
                        datawr_o   <= MODE_LOAD;
                        err_o      <= 1'b0;
                        count_o    <= '0;
                    end
                end
                S_CMD_LOAD: begin
                    state  <= S_STREAM;
                    to_cnt <= '0;
                end
                S_STREAM: begin
                    if (accept) begin
                        wr_o       <= 1'b1;
                        addr_rel_o <= 1'b1;
                        datawr_o   <= coeff_sext;
                        count_o    <= count_o + CNTW'(1);
                        to_cnt     <= '0;
                        if (count_o == CNTW'(NCOEFF - 1)) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAPW'(GAPCYC)) begin
                        state      <= S_CMD_RUN;
                        wr_o       <= 1'b1;
                        addr_rel_o <= 1'b0;
                        datawr_o   <= MODE_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + GAPW'(1);
                    end
                end
                S_CMD_RUN: begin
                    state  <= S_DONE;
                    done_o <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                S_CMD_STOP: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
            if (abort_now) begin
                state      <= S_CMD_STOP;
                wr_o       <= 1'b1;
                addr_rel_o <= 1'b0;
                datawr_o   <= MODE_STOP;
                err_o      <= 1'b1;
                done_o     <= 1'b0;
            end
        end
    end

endmodule
